ctrl_agen: RTL and testbench

Tap address generator for the upsampler controller. It consumes one fetched instruction's pointer fields and walks the data ring-buffer segment and the coefficient array, emitting one (data address, coefficient address) pair per MAC cycle. It sits directly downstream of the instruction-fetch register and feeds the data/coefficient RAM read ports and the MAC pipeline. Back-pressure comes from a ready input.

---
 rtl/ctrl_agen_pkg.sv | 23 ++
 rtl/ctrl_ring_dec.sv | 17 +
 rtl/ctrl_agen.sv | 162 ++++++++++++++++
 tb/tb_ctrl_agen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_agen_pkg.sv
`default_nettype none
// ctrl_agen_pkg: controller-wide field widths and state encodings (rev 1.0)
package ctrl_agen_pkg;

  localparam int VIDWIDTH_DEF = 5;
  localparam int RFAWIDTH_DEF = 5;
  localparam int DAWIDTH_DEF  = 12;

  // Allocation instruction: two flags, vector id, two reg addrs, four pointers.
  localparam int ALLOC_INSTR_WIDTH = 2 + VIDWIDTH_DEF + 2 * RFAWIDTH_DEF + 4 * DAWIDTH_DEF;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = STATE_IDLE,
    S_RUN  = STATE_RUN,
    S_DONE = STATE_DONE
  } agen_state_e;

endpackage
`default_nettype wire

// File: rtl/ctrl_ring_dec.sv
`default_nettype none
// ctrl_ring_dec: ring-buffer pointer decrement, lptr wraps to uptr (rev 1.0)
module ctrl_ring_dec #(
  parameter int DAWIDTH = 12
) (
  input  logic [DAWIDTH-1:0] addr,
  input  logic [DAWIDTH-1:0] lptr,
  input  logic [DAWIDTH-1:0] uptr,
  output logic [DAWIDTH-1:0] next_addr
);

  localparam logic [DAWIDTH-1:0] ADDR_ONE = {{(DAWIDTH-1){1'b0}}, 1'b1};

  assign next_addr = (addr == lptr) ? uptr : (addr - ADDR_ONE);

endmodule
`default_nettype wire

// File: rtl/ctrl_agen.sv
`default_nettype none
// ctrl_agen: walks a data ring segment and coefficient array, one pair per MAC cycle (rev 1.0)
module ctrl_agen
  import ctrl_agen_pkg::*;
#(
  parameter int VIDWIDTH = VIDWIDTH_DEF,
  parameter int RFAWIDTH = RFAWIDTH_DEF,
  parameter int DAWIDTH  = DAWIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                lstg_f,
  input  logic                upse_f,
  input  logic [VIDWIDTH-1:0] vector_id,
  input  logic [RFAWIDTH-1:0] result_reg,
  input  logic [RFAWIDTH-1:0] error_reg,
  input  logic [DAWIDTH-1:0]  data_uptr,
  input  logic [DAWIDTH-1:0]  data_lptr,
  input  logic [DAWIDTH-1:0]  data_head,
  input  logic [DAWIDTH-1:0]  coef_ptr,
  input  logic                addr_ready,
  output logic                busy,
  output logic                addr_valid,
  output logic [DAWIDTH-1:0]  data_addr,
  output logic [DAWIDTH-1:0]  coef_addr,
  output logic                tap_first,
  output logic                tap_last,
  output logic                done,
  output logic                cfg_err,
  output logic                o_lstg_f,
  output logic                o_upse_f,
  output logic [VIDWIDTH-1:0] o_vector_id,
  output logic [RFAWIDTH-1:0] o_result_reg,
  output logic [RFAWIDTH-1:0] o_error_reg
);

  localparam logic [DAWIDTH:0]   REM_ONE  = {{DAWIDTH{1'b0}}, 1'b1};
  localparam logic [DAWIDTH-1:0] ADDR_ONE = {{(DAWIDTH-1){1'b0}}, 1'b1};

  agen_state_e        state, state_next;
  logic [DAWIDTH:0]   remaining, rem_next;
  logic [DAWIDTH-1:0] lptr_q, uptr_q, lptr_next, uptr_next;
  logic [DAWIDTH-1:0] daddr_next, caddr_next, dec_addr;
  logic [DAWIDTH:0]   tap_count;
  logic               err_q, err_next, first_next, capture, illegal;

  ctrl_ring_dec #(.DAWIDTH(DAWIDTH)) u_ring_dec (
    .addr      (data_addr),
    .lptr      (lptr_q),
    .uptr      (uptr_q),
    .next_addr (dec_addr)
  );

  // Extra bit lets the full address space (N = 2^DAWIDTH) be represented.
  assign tap_count = {1'b0, data_uptr} - {1'b0, data_lptr} + REM_ONE;
  assign illegal   = (data_lptr > data_uptr) || (data_head < data_lptr) ||
                     (data_head > data_uptr);

  always_comb begin
    state_next = state;
    rem_next   = remaining;
    daddr_next = data_addr;
    caddr_next = coef_addr;
    lptr_next  = lptr_q;
    uptr_next  = uptr_q;
    err_next   = err_q;
    first_next = tap_first;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          lptr_next = data_lptr;
          uptr_next = data_uptr;
          if (illegal) begin
            err_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            err_next   = 1'b0;
            daddr_next = data_head;
            caddr_next = coef_ptr;
            rem_next   = tap_count;
            first_next = 1'b1;
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (addr_ready) begin
          first_next = 1'b0;
          if (remaining == REM_ONE) begin
            state_next = S_DONE;
          end else begin
            daddr_next = dec_addr;
            caddr_next = coef_addr + ADDR_ONE;
            rem_next   = remaining - REM_ONE;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every output is a flop fed from next-state values, so addr_ready never reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining  <= '0;
      lptr_q     <= '0;
      uptr_q     <= '0;
      err_q      <= 1'b0;
      data_addr  <= '0;
      coef_addr  <= '0;
      busy       <= 1'b0;
      addr_valid <= 1'b0;
      tap_first  <= 1'b0;
      tap_last   <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      remaining  <= rem_next;
      lptr_q     <= lptr_next;
      uptr_q     <= uptr_next;
      err_q      <= err_next;
      data_addr  <= daddr_next;
      coef_addr  <= caddr_next;
      busy       <= (state_next != S_IDLE);
      addr_valid <= (state_next == S_RUN);
      tap_first  <= first_next && (state_next == S_RUN);
      tap_last   <= (state_next == S_RUN) && (rem_next == REM_ONE);
      done       <= (state_next == S_DONE);
      cfg_err    <= (state_next == S_DONE) && err_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_lstg_f     <= 1'b0;
      o_upse_f     <= 1'b0;
      o_vector_id  <= '0;
      o_result_reg <= '0;
      o_error_reg  <= '0;
    end else if (capture) begin
      o_lstg_f     <= lstg_f;
      o_upse_f     <= upse_f;
      o_vector_id  <= vector_id;
      o_result_reg <= result_reg;
      o_error_reg  <= error_reg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_agen.sv
`default_nettype none
// tb_ctrl_agen: randomized self-checking bench for ctrl_agen against a pointer-arithmetic model (rev 1.0)
module tb_ctrl_agen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, lstg_f, upse_f, addr_ready;
  logic [4:0]  vector_id, result_reg, error_reg;
  logic [11:0] data_uptr, data_lptr, data_head, coef_ptr;
  logic        busy, addr_valid, tap_first, tap_last, done, cfg_err;
  logic [11:0] data_addr, coef_addr;
  logic        o_lstg_f, o_upse_f;
  logic [4:0]  o_vector_id, o_result_reg, o_error_reg;

  int checks   = 0;
  int failures = 0;

  ctrl_agen dut (
    .clk(clk), .rst(rst), .start(start), .lstg_f(lstg_f), .upse_f(upse_f),
    .vector_id(vector_id), .result_reg(result_reg), .error_reg(error_reg),
    .data_uptr(data_uptr), .data_lptr(data_lptr), .data_head(data_head),
    .coef_ptr(coef_ptr), .addr_ready(addr_ready), .busy(busy),
    .addr_valid(addr_valid), .data_addr(data_addr), .coef_addr(coef_addr),
    .tap_first(tap_first), .tap_last(tap_last), .done(done), .cfg_err(cfg_err),
    .o_lstg_f(o_lstg_f), .o_upse_f(o_upse_f), .o_vector_id(o_vector_id),
    .o_result_reg(o_result_reg), .o_error_reg(o_error_reg)
  );

  always #5 clk = ~clk;

  // Model: pair k reads the sample k steps older than head, wrapping inside [lp, up].
  function automatic int model_daddr(input int lp, input int up, input int hd, input int k);
    int n = up - lp + 1;
    return lp + ((((hd - lp - k) % n) + n) % n);
  endfunction

  task automatic issue_start(input int lp, input int up, input int hd, input int cp,
                             output logic [16:0] fields);
    @(posedge clk); #1;
    start      = 1'b1;
    lstg_f     = 1'($urandom);
    upse_f     = 1'($urandom);
    vector_id  = 5'($urandom);
    result_reg = 5'($urandom);
    error_reg  = 5'($urandom);
    data_lptr  = lp[11:0];
    data_uptr  = up[11:0];
    data_head  = hd[11:0];
    coef_ptr   = cp[11:0];
    fields     = {lstg_f, upse_f, vector_id, result_reg, error_reg};
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0, 2: random ready
  task automatic run_walk(input string name, input int lp, input int up, input int hd,
                          input int cp, input int mode);
    logic [16:0] fields;
    int n = up - lp + 1;
    int k = 0;
    int cyc = 0;
    int exp_d, exp_c;
    logic r;
    issue_start(lp, up, hd, cp, fields);
    checks++;
    if ({o_lstg_f, o_upse_f, o_vector_id, o_result_reg, o_error_reg} !== fields) begin
      failures++;
      $display("FAIL %s captured fields: got %h expected %h", name,
               {o_lstg_f, o_upse_f, o_vector_id, o_result_reg, o_error_reg}, fields);
    end
    while (k < n && cyc < 4 * n + 16) begin
      exp_d = model_daddr(lp, up, hd, k);
      exp_c = (cp + k) % 4096;
      checks++;
      if ({addr_valid, busy, data_addr, coef_addr, tap_first, tap_last, done} !==
          {1'b1, 1'b1, exp_d[11:0], exp_c[11:0], (k == 0), (k == n - 1), 1'b0}) begin
        failures++;
        $display("FAIL %s pair %0d: got v=%b d=%0d c=%0d f=%b l=%b done=%b expected d=%0d c=%0d f=%b l=%b",
                 name, k, addr_valid, data_addr, coef_addr, tap_first, tap_last, done,
                 exp_d, exp_c, (k == 0), (k == n - 1));
      end
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = (cyc % 3 == 0);
      else r = 1'($urandom_range(0, 1));
      addr_ready = r;
      if (r) k++;
      @(posedge clk); #1;
      cyc++;
    end
    addr_ready = 1'b1;
    if (k < n) begin
      failures++;
      $display("FAIL %s timeout: transferred %0d expected %0d", name, k, n);
    end
    checks++;
    if ({addr_valid, done, cfg_err} !== 3'b010) begin
      failures++;
      $display("FAIL %s done cycle: got valid/done/err=%b%b%b expected 010", name,
               addr_valid, done, cfg_err);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, addr_valid} !== 3'b000) begin
      failures++;
      $display("FAIL %s idle after done: got busy/done/valid=%b%b%b expected 000", name,
               busy, done, addr_valid);
    end
  endtask

  task automatic run_err(input string name, input int lp, input int up, input int hd);
    logic [16:0] fields;
    issue_start(lp, up, hd, 0, fields);
    checks++;
    if ({busy, done, cfg_err, addr_valid} !== 4'b1110) begin
      failures++;
      $display("FAIL %s error response: got busy/done/err/valid=%b%b%b%b expected 1110", name,
               busy, done, cfg_err, addr_valid);
    end
    checks++;
    if ({o_lstg_f, o_upse_f, o_vector_id, o_result_reg, o_error_reg} !== fields) begin
      failures++;
      $display("FAIL %s error captured fields: got %h expected %h", name,
               {o_lstg_f, o_upse_f, o_vector_id, o_result_reg, o_error_reg}, fields);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, cfg_err, addr_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL %s after error: got busy/done/err/valid=%b%b%b%b expected 0000", name,
               busy, done, cfg_err, addr_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, addr_valid, data_addr, coef_addr, tap_first, tap_last, done, cfg_err,
         o_lstg_f, o_upse_f, o_vector_id, o_result_reg, o_error_reg} !== 48'd0) begin
      failures++;
      $display("FAIL reset outputs: got d=%0d c=%0d busy=%b valid=%b vid=%0d expected all 0",
               data_addr, coef_addr, busy, addr_valid, o_vector_id);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_walk("basic", 16, 23, 19, 100, 0);
  endtask

  task automatic test_stall();
    run_walk("stall_pattern", 16, 23, 19, 100, 1);
    run_walk("stall_random", 16, 23, 19, 100, 2);
  endtask

  task automatic test_single();
    run_walk("single", 5, 5, 5, 77, 0);
  endtask

  task automatic test_errors();
    run_err("err_inverted", 30, 10, 20);
    run_err("err_head_high", 16, 23, 40);
    run_err("err_head_low", 16, 23, 3);
  endtask

  task automatic test_random();
    int lp, up, hd;
    for (int i = 0; i < 6; i++) begin
      lp = $urandom_range(0, 4000);
      up = lp + $urandom_range(0, 40);
      if (up > 4095) up = 4095;
      hd = $urandom_range(lp, up);
      run_walk("random", lp, up, hd, $urandom_range(4050, 4095), 2);
    end
  endtask

  task automatic test_full_segment();
    run_walk("full_segment", 0, 4095, 7, 4000, 0);
  endtask

  task automatic test_reset_mid();
    logic [16:0] fields;
    issue_start(16, 23, 19, 100, fields);
    addr_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, addr_valid, data_addr, coef_addr, tap_first, tap_last, done, cfg_err,
         o_lstg_f, o_upse_f, o_vector_id, o_result_reg, o_error_reg} !== 48'd0) begin
      failures++;
      $display("FAIL reset_mid async clear: got valid=%b d=%0d c=%0d busy=%b expected all 0",
               addr_valid, data_addr, coef_addr, busy);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({done, addr_valid, busy} !== 3'b000) begin
        failures++;
        $display("FAIL reset_mid quiet cycle %0d: got done/valid/busy=%b%b%b expected 000", i,
                 done, addr_valid, busy);
      end
    end
    run_walk("after_reset", 0, 9, 2, 500, 0);
  endtask

  task automatic test_restart_ignored();
    logic [16:0] fields;
    int exp_d;
    issue_start(16, 23, 19, 100, fields);
    addr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_d = model_daddr(16, 23, 19, k);
      checks++;
      if ({addr_valid, data_addr, coef_addr, tap_last} !==
          {1'b1, exp_d[11:0], 12'(100 + k), (k == 7)} ||
          {o_lstg_f, o_upse_f, o_vector_id, o_result_reg, o_error_reg} !== fields) begin
        failures++;
        $display("FAIL restart pair %0d: got d=%0d c=%0d fields=%h expected d=%0d c=%0d fields=%h",
                 k, data_addr, coef_addr,
                 {o_lstg_f, o_upse_f, o_vector_id, o_result_reg, o_error_reg},
                 exp_d, 100 + k, fields);
      end
      start = (k == 2 || k == 5);
      vector_id  = ~fields[14:10];
      result_reg = ~fields[9:5];
      data_head  = 12'd17;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if ({done, cfg_err, addr_valid} !== 3'b100) begin
      failures++;
      $display("FAIL restart done: got done/err/valid=%b%b%b expected 100", done, cfg_err,
               addr_valid);
    end
    @(posedge clk); #1;
    run_walk("restart_next", 16, 23, 17, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; addr_ready = 1'b0; lstg_f = 1'b0; upse_f = 1'b0;
    vector_id = '0; result_reg = '0; error_reg = '0;
    data_uptr = '0; data_lptr = '0; data_head = '0; coef_ptr = '0;
    test_reset();
    test_basic();
    test_stall();
    test_single();
    test_errors();
    test_random();
    test_full_segment();
    test_reset_mid();
    test_restart_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
